mipi_csi_rx_raw_depacker_nlane: RTL and testbench

Parametrised successor to the fixed 4-lane RAW depacker. It sits between the CSI-2 lane aligner / packet handler and the debayer path. It converts a byte stream of `LANES` bytes per clock into groups of `2*LANES` pixels. Each pixel is zero-extended to 16 bits. The RAW format (RAW8/10/12/14/16) is chosen per line at run time, and the block reports lines that end on a partial pixel group.

---
 rtl/mipi_csi_rx_raw_depacker_nlane_if.sv | 27 ++
 rtl/mipi_csi_rx_raw_depacker_nlane.sv | 168 ++++++++++++++++
 tb/tb_mipi_csi_rx_raw_depacker_nlane.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_csi_rx_raw_depacker_nlane_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mipi_csi_rx_raw_depacker_nlane_if: payload in / pixel group out.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mipi_csi_rx_raw_depacker_nlane_if #(
  parameter int LANES = 4
);
  logic                  data_valid_i;
  logic [8*LANES-1:0]    data_i;
  logic [2:0]            packet_type_i;
  logic                  output_valid_o;
  logic [32*LANES-1:0]   output_o;
  logic                  raw_line_o;
  logic                  line_err_o;

  modport master (
    output data_valid_i, data_i, packet_type_i,
    input  output_valid_o, output_o, raw_line_o, line_err_o
  );

  modport slave (
    input  data_valid_i, data_i, packet_type_i,
    output output_valid_o, output_o, raw_line_o, line_err_o
  );
endinterface
`default_nettype wire

// File: rtl/mipi_csi_rx_raw_depacker_nlane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mipi_csi_rx_raw_depacker_nlane: LANES bytes/clk -> 2*LANES px/group.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mipi_csi_rx_raw_depacker_nlane #(
  parameter int LANES = 4
) (
  input  wire                             clk_i,
  input  wire                             reset_n_i,
  mipi_csi_rx_raw_depacker_nlane_if.slave bus
);
  localparam int OUT_PIXELS = 2 * LANES;
  localparam int BUF_BYTES  = 5 * LANES;
  localparam int CW         = $clog2(BUF_BYTES);

  localparam logic [2:0] FMT_RAW8  = 3'd2;
  localparam logic [2:0] FMT_RAW10 = 3'd3;
  localparam logic [2:0] FMT_RAW12 = 3'd4;
  localparam logic [2:0] FMT_RAW14 = 3'd5;
  localparam logic [2:0] FMT_RAW16 = 3'd6;

  generate
    if (LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
      $error("mipi_csi_rx_raw_depacker_nlane: LANES must be 2, 4 or 8");
    end
  endgenerate

  // DISCARD swallows a whole line that started with a reserved format
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                fmt_q, fmt_d, fmt_eff;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [7:0]                byte_buf_q [BUF_BYTES];
  logic [7:0]                byte_buf_d [BUF_BYTES];
  logic [7:0]                merged     [BUF_BYTES];
  logic                      dv_q, dv_d;
  logic                      out_valid_q, out_valid_d;
  logic [16*OUT_PIXELS-1:0]  out_q, out_d;
  logic                      raw_line_q, raw_line_d;
  logic                      line_err_q, line_err_d;
  logic                      first_beat, line_end, take;
  logic [15:0]               px;
  int                        gb, fill;

  function automatic logic fmt_legal(input logic [2:0] f);
    return (f >= FMT_RAW8) && (f <= FMT_RAW16);
  endfunction

  function automatic int group_bytes(input logic [2:0] f);
    case (f)
      FMT_RAW10: return (5 * LANES) / 2;
      FMT_RAW12: return 3 * LANES;
      FMT_RAW14: return (7 * LANES) / 2;
      FMT_RAW16: return 4 * LANES;
      default:   return 2 * LANES;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    cnt_d       = cnt_q;
    byte_buf_d  = byte_buf_q;
    merged      = byte_buf_q;
    dv_d        = bus.data_valid_i;
    out_d       = out_q;
    out_valid_d = 1'b0;
    raw_line_d  = raw_line_q;
    line_err_d  = 1'b0;
    px          = '0;

    first_beat = bus.data_valid_i && !dv_q;
    line_end   = !bus.data_valid_i && dv_q;
    // the first beat is decoded with the format being latched on that edge
    fmt_eff    = first_beat ? bus.packet_type_i : fmt_q;
    take       = bus.data_valid_i &&
                 (first_beat ? fmt_legal(bus.packet_type_i) : (state_q == ST_ACTIVE));
    gb         = group_bytes(fmt_eff);
    fill       = int'(cnt_q) + LANES;

    if (first_beat) begin
      fmt_d   = bus.packet_type_i;
      state_d = fmt_legal(bus.packet_type_i) ? ST_ACTIVE : ST_DISCARD;
    end

    if (take) begin
      for (int i = 0; i < LANES; i++) begin
        merged[int'(cnt_q) + i] = bus.data_i[8*i +: 8];
      end
      if (fill >= gb) begin
        for (int k = 0; k < OUT_PIXELS; k++) begin
          case (fmt_eff)
            FMT_RAW8:  px = {8'h00, merged[k]};
            FMT_RAW10: px = {6'h00, merged[5*(k/4) + (k%4)],
                             2'(merged[5*(k/4) + 4] >> (2*(k%4)))};
            FMT_RAW12: px = {4'h0, merged[3*(k/2) + (k%2)],
                             4'(merged[3*(k/2) + 2] >> (4*(k%2)))};
            // RAW14 low bits are a packed 24-bit field across bytes 4..6
            FMT_RAW14: px = {2'b00, merged[7*(k/4) + (k%4)],
                             6'({merged[7*(k/4) + 6], merged[7*(k/4) + 5],
                                 merged[7*(k/4) + 4]} >> (6*(k%4)))};
            FMT_RAW16: px = {merged[2*k + 1], merged[2*k]};
            default:   px = '0;
          endcase
          out_d[16*k +: 16] = px;
        end
        for (int j = 0; j < BUF_BYTES; j++) begin
          byte_buf_d[j] = (j + gb < BUF_BYTES) ? merged[j + gb] : 8'h00;
        end
        cnt_d       = CW'(fill - gb);
        out_valid_d = 1'b1;
        raw_line_d  = 1'b1;
      end else begin
        byte_buf_d = merged;
        cnt_d      = CW'(fill);
      end
    end

    // residue is dropped, never emitted
    if (line_end) begin
      line_err_d = (state_q == ST_ACTIVE) && (cnt_q != '0);
      raw_line_d = 1'b0;
      cnt_d      = '0;
      state_d    = ST_IDLE;
      for (int j = 0; j < BUF_BYTES; j++) begin
        byte_buf_d[j] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      fmt_q       <= FMT_RAW8;
      cnt_q       <= '0;
      dv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      raw_line_q  <= 1'b0;
      line_err_q  <= 1'b0;
      for (int i = 0; i < BUF_BYTES; i++) begin
        byte_buf_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      cnt_q       <= cnt_d;
      dv_q        <= dv_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      raw_line_q  <= raw_line_d;
      line_err_q  <= line_err_d;
      byte_buf_q  <= byte_buf_d;
    end
  end

  assign bus.output_valid_o = out_valid_q;
  assign bus.output_o       = out_q;
  assign bus.raw_line_o     = raw_line_q;
  assign bus.line_err_o     = line_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_raw_depacker_nlane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mipi_csi_rx_raw_depacker_nlane: L=4 and L=2 depackers vs model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mipi_csi_rx_raw_depacker_nlane;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   fails = 0;

  logic         rec_v[$];
  logic         rec_l[$];
  logic         rec_e[$];
  logic [127:0] rec_o[$];

  mipi_csi_rx_raw_depacker_nlane_if #(.LANES(4)) bus4();
  mipi_csi_rx_raw_depacker_nlane_if #(.LANES(2)) bus2();

  mipi_csi_rx_raw_depacker_nlane #(.LANES(4)) dut4 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus4.slave)
  );

  mipi_csi_rx_raw_depacker_nlane #(.LANES(2)) dut2 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus2.slave)
  );

  always #5 clk = ~clk;

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference unpacking written straight from the per-format byte rules
  function automatic logic [127:0] model_group(input logic [2:0] f, input bq_t g);
    logic [15:0]  px[$];
    logic [127:0] r;
    r = '0;
    case (f)
      3'd2: foreach (g[i]) px.push_back({8'h00, g[i]});
      3'd3: for (int b = 0; b < g.size(); b += 5)
              for (int j = 0; j < 4; j++)
                px.push_back((16'(g[b+j]) << 2) | (16'(g[b+4] >> (2*j)) & 16'h0003));
      3'd4: for (int b = 0; b < g.size(); b += 3) begin
              px.push_back((16'(g[b])   << 4) | (16'(g[b+2]) & 16'h000F));
              px.push_back((16'(g[b+1]) << 4) | (16'(g[b+2]) >> 4));
            end
      3'd5: for (int b = 0; b < g.size(); b += 7) begin
              px.push_back((16'(g[b])   << 6) | (16'(g[b+4]) & 16'h003F));
              px.push_back((16'(g[b+1]) << 6) | ((16'(g[b+5]) & 16'h000F) << 2) | (16'(g[b+4]) >> 6));
              px.push_back((16'(g[b+2]) << 6) | ((16'(g[b+6]) & 16'h0003) << 4) | (16'(g[b+5]) >> 4));
              px.push_back((16'(g[b+3]) << 6) | (16'(g[b+6]) >> 2));
            end
      default: for (int b = 0; b < g.size(); b += 2) px.push_back({g[b+1], g[b]});
    endcase
    foreach (px[k]) r[16*k +: 16] = px[k];
    return r;
  endfunction

  task automatic sample(input int lanes);
    if (lanes == 4) begin
      rec_v.push_back(bus4.output_valid_o);
      rec_l.push_back(bus4.raw_line_o);
      rec_e.push_back(bus4.line_err_o);
      rec_o.push_back({96'h0, bus4.output_o});
    end else begin
      rec_v.push_back(bus2.output_valid_o);
      rec_l.push_back(bus2.raw_line_o);
      rec_e.push_back(bus2.line_err_o);
      rec_o.push_back({64'h0, bus2.output_o});
    end
  endtask

  // Drives one line, then two low cycles; one record per beat plus two tail records
  task automatic drive(input int lanes, input logic [2:0] pt0, input logic [2:0] pt1,
                       input int sw, input bq_t bytes);
    logic [31:0] d;
    rec_v.delete(); rec_l.delete(); rec_e.delete(); rec_o.delete();
    for (int b = 0; b < bytes.size() / lanes; b++) begin
      d = '0;
      for (int i = 0; i < lanes; i++) d[8*i +: 8] = bytes[b*lanes + i];
      if (lanes == 4) begin
        bus4.data_valid_i  = 1'b1;
        bus4.data_i        = d;
        bus4.packet_type_i = (b >= sw) ? pt1 : pt0;
      end else begin
        bus2.data_valid_i  = 1'b1;
        bus2.data_i        = d[15:0];
        bus2.packet_type_i = (b >= sw) ? pt1 : pt0;
      end
      @(posedge clk); #1;
      sample(lanes);
    end
    bus4.data_valid_i = 1'b0;
    bus2.data_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      sample(lanes);
    end
  endtask

  task automatic test_stream(input string name, input int lanes, input logic [2:0] pt0,
                             input logic [2:0] pt1, input int sw, input bq_t bytes);
    bq_t          pend, g;
    logic [127:0] grp, last;
    bit           have, legal, ev;
    int           nb, gb, emitted;
    drive(lanes, pt0, pt1, sw, bytes);
    nb      = bytes.size() / lanes;
    legal   = (pt0 >= 3'd2) && (pt0 <= 3'd6);
    gb      = lanes * (2 * int'(pt0) + 4) / 4;
    emitted = 0;
    have    = 1'b0;
    last    = '0;
    for (int r = 0; r < nb; r++) begin
      for (int i = 0; i < lanes; i++) pend.push_back(bytes[r*lanes + i]);
      ev = 1'b0;
      if (legal && pend.size() >= gb) begin
        g.delete();
        for (int i = 0; i < gb; i++) g.push_back(pend.pop_front());
        grp = model_group(pt0, g);
        ev  = 1'b1;
        emitted++;
      end
      tests_run++;
      if (rec_v[r] !== ev) begin
        fails++;
        $display("FAIL %s valid[%0d]: got %0b want %0b", name, r, rec_v[r], ev);
      end
      if (ev || have) begin
        tests_run++;
        if (rec_o[r] !== (ev ? grp : last)) begin
          fails++;
          $display("FAIL %s output[%0d]: got %h want %h", name, r, rec_o[r], ev ? grp : last);
        end
      end
      if (ev) begin
        last = grp;
        have = 1'b1;
      end
      tests_run++;
      if (rec_l[r] !== (emitted > 0) || rec_e[r] !== 1'b0) begin
        fails++;
        $display("FAIL %s line/err[%0d]: got %0b/%0b want %0b/0", name, r, rec_l[r], rec_e[r],
                 emitted > 0);
      end
    end
    tests_run++;
    if (rec_v[nb] !== 1'b0 || rec_l[nb] !== 1'b0 ||
        rec_e[nb] !== (legal && pend.size() != 0) || rec_e[nb+1] !== 1'b0) begin
      fails++;
      $display("FAIL %s line_end: got v%0b l%0b e%0b e+1=%0b want v0 l0 e%0b e+1=0", name,
               rec_v[nb], rec_l[nb], rec_e[nb], rec_e[nb+1], legal && pend.size() != 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.data_valid_i = 1'b0; bus4.data_i = '0; bus4.packet_type_i = 3'd0;
    bus2.data_valid_i = 1'b0; bus2.data_i = '0; bus2.packet_type_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus4.output_valid_o, bus4.raw_line_o, bus4.line_err_o} !== 3'b000 || bus4.output_o !== '0) begin
      fails++;
      $display("FAIL reset_l4: got v%0b l%0b e%0b o%h want all 0", bus4.output_valid_o,
               bus4.raw_line_o, bus4.line_err_o, bus4.output_o);
    end
    tests_run++;
    if ({bus2.output_valid_o, bus2.raw_line_o, bus2.line_err_o} !== 3'b000 || bus2.output_o !== '0) begin
      fails++;
      $display("FAIL reset_l2: got v%0b l%0b e%0b o%h want all 0", bus2.output_valid_o,
               bus2.raw_line_o, bus2.line_err_o, bus2.output_o);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus4.output_valid_o, bus4.raw_line_o, bus4.line_err_o} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 000",
               {bus4.output_valid_o, bus4.raw_line_o, bus4.line_err_o});
    end
  endtask

  task automatic test_raw14();
    bq_t q;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05,
          8'h06, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h09, 8'h0A};
    q = {q, rand_bytes(4)};
    test_stream("raw14_group", 4, 3'd5, 3'd5, 99, q);
    tests_run++;
    if (rec_v[3] !== 1'b1 || rec_o[3] !== {64'h0, 16'h0200, 16'h01C0, 16'h0180, 16'h0140,
                                           16'h0100, 16'h00C0, 16'h0080, 16'h0040}) begin
      fails++;
      $display("FAIL raw14_pixels: got v%0b %h want v1 spec pixels", rec_v[3], rec_o[3]);
    end
    tests_run++;
    if (rec_l[2] !== 1'b0 || rec_l[3] !== 1'b1) begin
      fails++;
      $display("FAIL raw14_line_rise: got %0b%0b want 01", rec_l[2], rec_l[3]);
    end
    tests_run++;
    if (rec_e[5] !== 1'b1 || rec_l[5] !== 1'b0 || rec_e[6] !== 1'b0 || rec_v[4] !== 1'b0) begin
      fails++;
      $display("FAIL raw14_residue: got e%0b l%0b e+1=%0b v%0b want e1 l0 e+1=0 v0",
               rec_e[5], rec_l[5], rec_e[6], rec_v[4]);
    end
    test_stream("raw14_next_line", 4, 3'd5, 3'd5, 99, rand_bytes(28));
    tests_run++;
    if (rec_v[1] !== 1'b0 || rec_v[3] !== 1'b1 || rec_v[6] !== 1'b1) begin
      fails++;
      $display("FAIL raw14_flush: got v1=%0b v3=%0b v6=%0b want 0 1 1", rec_v[1], rec_v[3], rec_v[6]);
    end
  endtask

  task automatic test_raw10();
    bq_t q;
    for (int i = 0; i < 8; i++) q = {q, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE4};
    test_stream("raw10", 4, 3'd3, 3'd3, 99, q);
    tests_run++;
    if (rec_v[2] !== 1'b1 || rec_o[2] !== {64'h0, 16'h0013, 16'h000E, 16'h0009, 16'h0004,
                                           16'h0013, 16'h000E, 16'h0009, 16'h0004}) begin
      fails++;
      $display("FAIL raw10_pixels: got v%0b %h want v1 spec pixels", rec_v[2], rec_o[2]);
    end
  endtask

  task automatic test_raw16();
    bq_t q;
    for (int i = 0; i < 8; i++) q = {q, 8'h11, 8'h11, 8'h22, 8'h22};
    test_stream("raw16", 4, 3'd6, 3'd6, 99, q);
    tests_run++;
    if ({rec_v[0], rec_v[1], rec_v[2], rec_v[3], rec_v[4], rec_v[5], rec_v[6], rec_v[7]} !== 8'b00010001
        || rec_o[7] !== {64'h0, {4{16'h2222, 16'h1111}}} || rec_e[8] !== 1'b0) begin
      fails++;
      $display("FAIL raw16_cadence: got v3=%0b v7=%0b o=%h e=%0b want cadence 00010001 alternating 1111/2222",
               rec_v[3], rec_v[7], rec_o[7], rec_e[8]);
    end
  endtask

  task automatic test_format_latch();
    int nv;
    test_stream("latch", 4, 3'd5, 3'd2, 4, rand_bytes(32));
    nv = 0;
    foreach (rec_v[i]) nv += int'(rec_v[i]);
    tests_run++;
    if (nv !== 2) begin
      fails++;
      $display("FAIL latch_groups: got %0d want 2", nv);
    end
    test_stream("reserved", 4, 3'd7, 3'd2, 3, rand_bytes(24));
    nv = 0;
    foreach (rec_v[i]) nv += int'(rec_v[i]) + int'(rec_l[i]) + int'(rec_e[i]);
    tests_run++;
    if (nv !== 0) begin
      fails++;
      $display("FAIL reserved_silent: got %0d active samples want 0", nv);
    end
  endtask

  task automatic test_random();
    int lanes, nb;
    for (int n = 0; n < 16; n++) begin
      lanes = ($urandom_range(0, 1) == 1) ? 4 : 2;
      nb    = $urandom_range(1, 24);
      test_stream("random", lanes, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(1, nb), rand_bytes(nb * lanes));
    end
  endtask

  task automatic test_async_reset();
    bq_t          q;
    logic [127:0] exp;
    q = rand_bytes(12);
    for (int i = 0; i < 12; i++) q[i] = q[i] | 8'h01;
    exp = model_group(3'd4, q);
    for (int b = 0; b < 3; b++) begin
      bus4.data_valid_i  = 1'b1;
      bus4.packet_type_i = 3'd4;
      bus4.data_i        = {q[4*b+3], q[4*b+2], q[4*b+1], q[4*b]};
      @(posedge clk); #1;
    end
    tests_run++;
    if (bus4.output_valid_o !== 1'b1 || bus4.raw_line_o !== 1'b1 || {96'h0, bus4.output_o} !== exp) begin
      fails++;
      $display("FAIL arst_pre: got v%0b l%0b %h want v1 l1 %h", bus4.output_valid_o,
               bus4.raw_line_o, bus4.output_o, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus4.output_valid_o, bus4.raw_line_o, bus4.line_err_o} !== 3'b000 || bus4.output_o !== '0) begin
      fails++;
      $display("FAIL arst_immediate: got v%0b l%0b e%0b %h want all 0", bus4.output_valid_o,
               bus4.raw_line_o, bus4.line_err_o, bus4.output_o);
    end
    bus4.data_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus4.line_err_o !== 1'b0 || bus4.raw_line_o !== 1'b0) begin
      fails++;
      $display("FAIL arst_no_err: got e%0b l%0b want 0 0", bus4.line_err_o, bus4.raw_line_o);
    end
    q = rand_bytes(12);
    test_stream("arst_raw8_l2", 2, 3'd2, 3'd2, 99, q);
    tests_run++;
    if (rec_v[0] !== 1'b0 || rec_v[1] !== 1'b1 ||
        rec_o[1] !== {64'h0, 8'h00, q[3], 8'h00, q[2], 8'h00, q[1], 8'h00, q[0]}) begin
      fails++;
      $display("FAIL arst_raw8_l2_px: got v%0b%0b %h want 01 bytes %h %h %h %h", rec_v[0], rec_v[1],
               rec_o[1], q[3], q[2], q[1], q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_raw14();
    test_raw10();
    test_raw16();
    test_format_latch();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
`default_nettype wire
